// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Arbitrates, issues one registered op per transaction, holds the response and the NZCV flags.
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int PRIO_RR = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_setflags,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_setflags,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,

  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,

  output logic [3:0]        flags_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        issue_op;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic              issue_setflags;
  logic              issue_err;
  logic              issue_id;
  logic              last_grant;

  logic              grant_valid;
  logic              grant_id;
  logic              accept;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_setflags;
  logic              sel_legal;
  logic              rsp_taken;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10: legal = 1'b1;
      default:                                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // With only one valid, the winner is simply the one asking; contention uses the policy.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = (PRIO_RR != 0) ? ~last_grant : 1'b0;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  always_comb begin
    sel_op       = grant_id ? req1_op       : req0_op;
    sel_a        = grant_id ? req1_a        : req0_a;
    sel_b        = grant_id ? req1_b        : req0_b;
    sel_setflags = grant_id ? req1_setflags : req0_setflags;
    sel_legal    = op_is_legal(sel_op);
  end

  assign rsp_taken = issue_id ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_taken) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Illegal opcodes are latched as op 0 so the ALU sees a benign control word in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_op       <= '0;
      issue_a        <= '0;
      issue_b        <= '0;
      issue_setflags <= 1'b0;
      issue_err      <= 1'b0;
      issue_id       <= 1'b0;
      last_grant     <= 1'b1;
    end else if (accept) begin
      issue_op       <= sel_legal ? sel_op : 4'd0;
      issue_a        <= sel_a;
      issue_b        <= sel_b;
      issue_setflags <= sel_setflags;
      issue_err      <= ~sel_legal;
      issue_id       <= grant_id;
      last_grant     <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      flags_q    <= '0;
    end else if (state_q == EXEC) begin
      if (issue_err) begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_err    <= 1'b1;
      end else begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
        rsp_err    <= 1'b0;
        if (issue_setflags) begin
          flags_q <= {alu_n, alu_z, alu_c, alu_v};
        end
      end
    end
  end

  assign alu_control = issue_op;
  assign alu_a       = issue_a;
  assign alu_b       = issue_b;

  assign rsp0_valid  = (state_q == RESP) && !issue_id;
  assign rsp1_valid  = (state_q == RESP) &&  issue_id;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized transaction-level check of alu_share_arbiter against an abstract model,
// plus a second fixed-priority instance checked for its 3-cycle grant cadence.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req0_setflags;
  logic [3:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_setflags;
  logic [3:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic [3:0]   flags_q;
  logic         busy;

  logic         fp_req0_ready, fp_req1_ready;
  logic         fp_rsp0_valid, fp_rsp1_valid, fp_rsp_err, fp_busy;
  logic [W-1:0] fp_rsp_result, fp_alu_a, fp_alu_b, fp_alu_result;
  logic [3:0]   fp_rsp_flags, fp_alu_control, fp_flags_q;
  logic         fp_alu_n, fp_alu_z, fp_alu_c, fp_alu_v;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic       m_last;
  logic [3:0] m_flags;

  // Reference ALU: returns {N,Z,C,V,result}; C on subtract means borrow.
  function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, v;
    wide = '0; c = 1'b0; v = 1'b0; r = '0;
    case (op)
      4'd0, 4'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd1, 4'd3, 4'd4: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd7:    r = a & b;
      4'd8:    r = a | b;
      4'd9:    r = a ^ b;
      4'd10:   r = ~b;
      default: r = '0;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_model(alu_control, alu_a, alu_b);
  assign {fp_alu_n, fp_alu_z, fp_alu_c, fp_alu_v, fp_alu_result} =
         alu_model(fp_alu_control, fp_alu_a, fp_alu_b);

  alu_share_arbiter #(.DATA_W(W), .PRIO_RR(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setflags(req0_setflags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_setflags(req1_setflags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flags_q(flags_q), .busy(busy)
  );

  alu_share_arbiter #(.DATA_W(W), .PRIO_RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(1'b1), .req0_ready(fp_req0_ready), .req0_op(4'd0),
    .req0_a(32'd100), .req0_b(32'd23), .req0_setflags(1'b0),
    .req1_valid(1'b1), .req1_ready(fp_req1_ready), .req1_op(4'd1),
    .req1_a(32'd7), .req1_b(32'd2), .req1_setflags(1'b0),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(1'b1),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err),
    .alu_control(fp_alu_control), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
    .alu_result(fp_alu_result),
    .alu_n(fp_alu_n), .alu_z(fp_alu_z), .alu_c(fp_alu_c), .alu_v(fp_alu_v),
    .flags_q(fp_flags_q), .busy(fp_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic scramble_req();
    req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
    req0_op = 4'($urandom_range(0, 15));   req1_op = 4'($urandom_range(0, 15));
    req0_a = $urandom; req0_b = $urandom;  req1_a = $urandom; req1_b = $urandom;
    req0_setflags = 1'($urandom_range(0, 1)); req1_setflags = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input logic v0, input logic [3:0] op0, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input logic sf0,
                         input logic v1, input logic [3:0] op1, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic sf1, input int unsigned hold);
    logic g, sf, legal;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [35:0] exp;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_setflags = sf0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_setflags = sf1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    if (!v0 && !v1) begin
      check("idle_rdy", 64'({req0_ready, req1_ready}), 64'(0));
      @(posedge clk); #1;
      check("idle_busy", 64'(busy), 64'(0));
      return;
    end
    g     = (v0 && v1) ? ~m_last : v1;
    op    = g ? op1 : op0;
    a     = g ? a1 : a0;
    b     = g ? b1 : b0;
    sf    = g ? sf1 : sf0;
    legal = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
    exp   = legal ? alu_model(op, a, b) : '0;
    check("acc_rdy0", 64'(req0_ready), 64'(g == 1'b0));
    check("acc_rdy1", 64'(req1_ready), 64'(g == 1'b1));
    m_last = g;
    @(posedge clk); #1;
    scramble_req(); #1;
    check("exec_busy", 64'(busy), 64'(1));
    check("exec_rdy", 64'({req0_ready, req1_ready}), 64'(0));
    check("exec_rspv", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check("exec_ctrl", 64'(alu_control), 64'(legal ? op : 4'd0));
    if (legal) begin
      check("exec_a", 64'(alu_a), 64'(a));
      check("exec_b", 64'(alu_b), 64'(b));
    end
    @(posedge clk); #1;
    if (legal && sf) m_flags = exp[35:32];
    for (int unsigned i = 0; i <= hold; i++) begin
      scramble_req();
      rsp0_ready = g ? 1'b1 : (i == hold);
      rsp1_ready = g ? (i == hold) : 1'b1;
      #1;
      check("resp_v0", 64'(rsp0_valid), 64'(g == 1'b0));
      check("resp_v1", 64'(rsp1_valid), 64'(g == 1'b1));
      check("resp_res", 64'(rsp_result), 64'(exp[W-1:0]));
      check("resp_flg", 64'(rsp_flags), 64'(exp[35:32]));
      check("resp_err", 64'(rsp_err), 64'(!legal));
      check("resp_fq", 64'(flags_q), 64'(m_flags));
      check("resp_rdy", 64'({req0_ready, req1_ready}), 64'(0));
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("post_busy", 64'(busy), 64'(0));
    check("post_rspv", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check("post_fq", 64'(flags_q), 64'(m_flags));
  endtask

  initial begin
    rst = 1'b1; m_last = 1'b1; m_flags = '0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; req0_setflags = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; req1_setflags = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rdy", 64'({req0_ready, req1_ready}), 64'(0));
    check("rst_rspv", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check("rst_rsp", 64'({rsp_result, rsp_flags, rsp_err}), 64'(0));
    check("rst_alu", 64'({alu_control, alu_a}), 64'(0));
    check("rst_alub", 64'(alu_b), 64'(0));
    check("rst_fq", 64'(flags_q), 64'(0));
    rst = 1'b0;

    // Fixed-priority instance: both always valid, req0 must win every 3-cycle round.
    for (int k = 0; k < 9; k++) begin
      #1;
      case (k % 3)
        0: begin
          check("fp_busy0", 64'(fp_busy), 64'(0));
          check("fp_rdy", 64'({fp_req0_ready, fp_req1_ready}), 64'(2'b10));
        end
        1: begin
          check("fp_busy1", 64'(fp_busy), 64'(1));
          check("fp_ctrl", 64'(fp_alu_control), 64'(0));
        end
        default: begin
          check("fp_rspv", 64'({fp_rsp0_valid, fp_rsp1_valid}), 64'(2'b10));
          check("fp_res", 64'(fp_rsp_result), 64'(123));
        end
      endcase
      @(posedge clk); #1;
    end

    run_txn(1, 4'd0, 32'd5, 32'd3, 0,  0, 4'd0, '0, '0, 0, 0);
    run_txn(0, 4'd0, '0, '0, 0,        1, 4'd3, 32'd3, 32'd3, 1, 0);
    run_txn(1, 4'd5, 32'd9, 32'd4, 1,  0, 4'd0, '0, '0, 0, 0);
    run_txn(1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1, 0, 4'd0, '0, '0, 0, 5);
    for (int i = 0; i < 6; i++)
      run_txn(1, 4'd2, 32'(i), 32'd1, 0, 1, 4'd1, 32'd10, 32'(i), 0, 0);
    for (int i = 0; i < 50; i++)
      run_txn(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // Reset landing in EXEC drops the op and restores req0-first arbitration.
    run_txn(0, 4'd0, '0, '0, 0, 1, 4'd3, 32'd3, 32'd3, 1, 0);
    req0_valid = 1; req0_op = 4'd3; req0_a = 32'd1; req0_b = 32'd2; req0_setflags = 1;
    @(posedge clk); #1;
    req0_valid = 0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_flags = '0; m_last = 1'b1;
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_rspv", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check("mrst_fq", 64'(flags_q), 64'(0));
    check("mrst_rsp", 64'({rsp_result, rsp_flags, rsp_err}), 64'(0));
    check("mrst_ctrl", 64'(alu_control), 64'(0));
    run_txn(1, 4'd7, 32'hF0F0, 32'h0FF0, 1, 1, 4'd8, 32'h1, 32'h2, 1, 1);
    run_txn(1, 4'd9, 32'hAAAA, 32'h5555, 0, 1, 4'd10, 32'h0, 32'h0, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
